// File: rtl/alu_op_issuer.sv
// -----------------------------------------------------------------------------
// alu_op_issuer
//
// Front-end sequencer for a combinational ALU. A request (opcode, A, B, tag) is
// taken over a valid/ready handshake, issued to the ALU for exactly one cycle,
// and the ALU result is captured into a small in-order response FIFO together
// with the request tag. Illegal opcodes never reach the ALU. Each one produces
// an error response and bumps a saturating counter.
//
// Handshake semantics (both channels): a transfer happens on a rising edge
// where valid && ready are both high. A producer holding valid keeps its
// payload stable until the transfer. ready never depends combinationally on
// valid.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready        request handshake
//   req_opcode/req_a/req_b     request opcode and operands
//   req_tag                    request identifier, returned unchanged
//   alu_a/alu_b/alu_opcode     registered operands to the ALU (hold when idle)
//   alu_en                     ALU enable, high only during the issue cycle
//   alu_result                 combinational ALU result
//   rsp_valid/rsp_ready        response handshake (FIFO head)
//   rsp_data/rsp_tag/rsp_err   response payload, all zero while FIFO empty
//   busy                       FSM not idle or responses pending
//   err_count                  saturating count of illegal opcodes
// -----------------------------------------------------------------------------
module alu_op_issuer #(
    parameter int DATA_W    = 16,
    parameter int TAG_W     = 4,
    parameter int RSP_DEPTH = 2,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [3:0]           req_opcode,
    input  logic [DATA_W-1:0]    req_a,
    input  logic [DATA_W-1:0]    req_b,
    input  logic [TAG_W-1:0]     req_tag,
    output logic [DATA_W-1:0]    alu_a,
    output logic [DATA_W-1:0]    alu_b,
    output logic [3:0]           alu_opcode,
    output logic                 alu_en,
    input  logic [DATA_W-1:0]    alu_result,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [DATA_W-1:0]    rsp_data,
    output logic [TAG_W-1:0]     rsp_tag,
    output logic                 rsp_err,
    output logic                 busy,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CNT_W = $clog2(RSP_DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RSP_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RSP_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_REJECT = 2'd2
    } state_e;

    function automatic logic is_legal(input logic [3:0] op);
        return (op == 4'b0000) || (op == 4'b0001) ||
               (op == 4'b0010) || (op == 4'b0100);
    endfunction

    state_e               state_q, state_d;
    logic [TAG_W-1:0]     tag_q, tag_d;
    logic [DATA_W-1:0]    alu_a_q, alu_a_d;
    logic [DATA_W-1:0]    alu_b_q, alu_b_d;
    logic [3:0]           alu_op_q, alu_op_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic [DATA_W-1:0]    fifo_data_q [RSP_DEPTH];
    logic [DATA_W-1:0]    fifo_data_d [RSP_DEPTH];
    logic [TAG_W-1:0]     fifo_tag_q  [RSP_DEPTH];
    logic [TAG_W-1:0]     fifo_tag_d  [RSP_DEPTH];
    logic                 fifo_err_q  [RSP_DEPTH];
    logic                 fifo_err_d  [RSP_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic                 can_accept;
    logic                 push;
    logic [DATA_W-1:0]    push_data;
    logic                 push_err;
    logic                 pop;

    // Acceptance looks only at the registered count. A pop in the same cycle
    // frees a slot that becomes visible one cycle later.
    assign can_accept = (state_q == ST_IDLE) && (cnt_q < CNT_FULL);
    assign rsp_valid  = (cnt_q != '0);
    assign pop        = rsp_valid && rsp_ready;

    // ---------------- sequencer: next state and outputs ----------------
    always_comb begin
        state_d   = state_q;
        tag_d     = tag_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_op_d  = alu_op_q;
        err_cnt_d = err_cnt_q;
        req_ready = 1'b0;
        alu_en    = 1'b0;
        push      = 1'b0;
        push_data = '0;
        push_err  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = can_accept;
                if (req_valid && can_accept) begin
                    tag_d = req_tag;
                    if (is_legal(req_opcode)) begin
                        // ALU ports change only for legal requests, so a
                        // rejected request leaves them untouched.
                        alu_a_d  = req_a;
                        alu_b_d  = req_b;
                        alu_op_d = req_opcode;
                        state_d  = ST_ISSUE;
                    end else begin
                        state_d = ST_REJECT;
                    end
                end
            end
            ST_ISSUE: begin
                alu_en    = 1'b1;
                push      = 1'b1;
                push_data = alu_result;
                state_d   = ST_IDLE;
            end
            ST_REJECT: begin
                push     = 1'b1;
                push_err = 1'b1;
                if (err_cnt_q != '1) begin
                    err_cnt_d = err_cnt_q + 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ---------------- response FIFO next state ----------------
    always_comb begin
        fifo_data_d = fifo_data_q;
        fifo_tag_d  = fifo_tag_q;
        fifo_err_d  = fifo_err_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q;
        if (push) begin
            fifo_data_d[wr_ptr_q] = push_data;
            fifo_tag_d[wr_ptr_q]  = tag_q;
            fifo_err_d[wr_ptr_q]  = push_err;
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // ---------------- state registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            tag_q     <= '0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_op_q  <= '0;
            err_cnt_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            for (int i = 0; i < RSP_DEPTH; i++) begin
                fifo_data_q[i] <= '0;
                fifo_tag_q[i]  <= '0;
                fifo_err_q[i]  <= 1'b0;
            end
        end else begin
            state_q     <= state_d;
            tag_q       <= tag_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            err_cnt_q   <= err_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            fifo_data_q <= fifo_data_d;
            fifo_tag_q  <= fifo_tag_d;
            fifo_err_q  <= fifo_err_d;
        end
    end

    // ---------------- outputs ----------------
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_opcode = alu_op_q;
    assign err_count  = err_cnt_q;
    assign busy       = (state_q != ST_IDLE) || rsp_valid;
    // The payload reads zero while empty instead of showing stale entries.
    assign rsp_data   = rsp_valid ? fifo_data_q[rd_ptr_q] : '0;
    assign rsp_tag    = rsp_valid ? fifo_tag_q[rd_ptr_q]  : '0;
    assign rsp_err    = rsp_valid ? fifo_err_q[rd_ptr_q]  : 1'b0;

endmodule

// File: doc/alu_op_issuer.md
Name: alu_op_issuer

Overview:
- Front-end sequencer that drives the combinational 16-bit ALU (opcode/A/B/en → result).
- Accepts operation requests over a valid/ready handshake and latches the operands.
- Drives the ALU enable and operand ports for exactly one cycle, then captures the ALU result.
- Returns the result with its request tag through a small response FIFO with valid/ready backpressure. Illegal opcodes are rejected without touching the ALU.

Parameters:
- DATA_W, 16: operand and result width; must match the ALU.
- TAG_W, 4: request tag width; the tag is passed through unchanged.
- RSP_DEPTH, 2: response FIFO entries; must be 2 or more.
- ERR_CNT_W, 8: width of the saturating illegal-opcode counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  issuer can accept a request this cycle.
- req_opcode  in  4  ALU opcode.
- req_a  in  DATA_W  operand A.
- req_b  in  DATA_W  operand B.
- req_tag  in  TAG_W  request identifier.
- alu_a  out  DATA_W  to ALU A.
- alu_b  out  DATA_W  to ALU B.
- alu_opcode  out  4  to ALU opcode.
- alu_en  out  1  to ALU en.
- alu_result  in  DATA_W  from ALU result; combinational in the same cycle.
- rsp_valid  out  1  response FIFO head is valid.
- rsp_ready  in  1  consumer accepts the head.
- rsp_data  out  DATA_W  result; 0 on error.
- rsp_tag  out  TAG_W  tag of the request that produced this response.
- rsp_err  out  1  opcode was illegal.
- busy  out  1  state is not IDLE, or the FIFO is non-empty.
- err_count  out  ERR_CNT_W  illegal opcodes seen; saturates at all-ones.

Behaviour:
- Legal opcodes:
  - 4'b0000 ADD.
  - 4'b0001 SUB.
  - 4'b0010 GT: signed, result 1/0.
  - 4'b0100 LE: signed, result 1/0.
  - All other encodings are illegal.
- Reset (rst_n low, asynchronous):
  - State goes to IDLE and the FIFO empties.
  - rsp_valid=0, alu_en=0, alu_a/alu_b/alu_opcode=0, err_count=0, busy=0.
  - rsp_data, rsp_tag and rsp_err read 0 while the FIFO is empty.
- State IDLE:
  - req_ready = (fifo_count < RSP_DEPTH).
  - On req_valid && req_ready: latch opcode/a/b/tag into operand registers.
  - Legal opcode: go to ISSUE.
  - Illegal opcode: go to REJECT.
- State ISSUE (exactly one cycle):
  - alu_en=1; alu_a/alu_b/alu_opcode driven from the operand registers.
  - req_ready=0.
  - At the clock edge ending the cycle, push {alu_result, tag, err=0} into the FIFO and return to IDLE.
- State REJECT (exactly one cycle):
  - alu_en=0; ALU ports hold their previous values.
  - req_ready=0.
  - At the ending edge, push {0, tag, err=1}, increment err_count (saturating), and return to IDLE.
- alu_en is 0 in every state except ISSUE.
  - Outside ISSUE, alu_a/alu_b/alu_opcode hold their last values; they are not cleared.
- Latency: request accepted at edge N → ISSUE/REJECT during cycle N+1 → rsp_valid high from cycle N+2 (FIFO empty, no contention).
- Throughput: at most one request per 2 cycles.
- FIFO:
  - Registered storage, in-order.
  - Pop on rsp_valid && rsp_ready.
  - Push and pop in the same cycle are both performed and fifo_count is unchanged.
  - Read/write pointers wrap modulo RSP_DEPTH.
  - No overflow is possible: entry from IDLE requires count < RSP_DEPTH, and count can only decrease before the push.
- Simultaneous events:
  - rsp_ready arriving while count == RSP_DEPTH in IDLE: req_ready stays 0 that cycle (computed from the registered count) and goes to 1 the cycle after the pop.
- rsp_data/rsp_tag/rsp_err are stable while rsp_valid && !rsp_ready.
- Reset mid-operation (ISSUE/REJECT or a non-empty FIFO): in-flight and buffered responses are discarded and no push occurs.

Test Plan:
- ADD: opcode 0, a=0x0003, b=0x0004, tag=5 → alu_en high exactly 1 cycle; rsp_valid 2 cycles after acceptance with rsp_data=0x0007, rsp_tag=5, rsp_err=0.
- SUB and wrap:
  - SUB a=0x0005, b=0x0007 → rsp_data=0xFFFE.
  - ADD a=0xFFFF, b=0x0001 → 0x0000.
- Signed compare:
  - GT a=0x0001, b=0xFFFF → 0x0001.
  - LE a=0x8000, b=0x7FFF → 0x0001.
  - GT a=0x1234, b=0x1234 → 0x0000.
- Illegal opcode 4'b0011, tag=9 → alu_en never asserted; rsp_err=1, rsp_data=0, rsp_tag=9; err_count increments to 1. 256 illegal requests → err_count saturates at 0xFF.
- Backpressure: rsp_ready=0, issue 3 back-to-back requests with RSP_DEPTH=2 → the first two are accepted, then req_ready=0. Pulse rsp_ready for 1 cycle → req_ready=1 the next cycle; responses pop in tag order.
- Reset mid-operation: assert rst_n=0 during ISSUE with 1 response buffered → alu_en and rsp_valid drop immediately (asynchronously); after release, busy=0, FIFO empty, and the next request behaves as on the first ADD scenario.
